// File: rtl/line_buffer_dport_pkg.sv
// ============================================================================
// line_buffer_dport_pkg : shared constants, FSM states and MMIO predicate
// Revision 1.0
// ============================================================================
`default_nettype none

package line_buffer_dport_pkg;

    localparam int          LINE_BYTES = 64;
    localparam int          WORD_BITS  = 64;
    localparam logic [63:0] MMIO_LO    = 64'd655360;    // 640 KiB
    localparam logic [63:0] MMIO_HI    = 64'd1048576;   // 1 MiB

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lb_state_e;

    // Both window bounds are exclusive, so the bounds themselves are cacheable.
    function automatic logic is_cacheable(input logic [63:0] addr,
                                          input logic [63:0] lo,
                                          input logic [63:0] hi);
        return (addr <= lo) || (addr >= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_word_mux.sv
// ============================================================================
// line_word_mux : selects one word of a line and builds the line with that
//                 word replaced by write data
// Revision 1.0
// ============================================================================
`default_nettype none

module line_word_mux #(
    parameter int WORDS     = 8,
    parameter int WORD_BITS = line_buffer_dport_pkg::WORD_BITS
) (
    input  logic [WORDS*WORD_BITS-1:0] i_line,
    input  logic [$clog2(WORDS)-1:0]   i_index,
    input  logic [WORD_BITS-1:0]       i_wdata,
    output logic [WORDS*WORD_BITS-1:0] o_line,
    output logic [WORD_BITS-1:0]       o_word
);

    localparam int IDX_W = $clog2(WORDS);

    logic [WORD_BITS-1:0] w_words [WORDS];

    for (genvar k = 0; k < WORDS; k++) begin : g_word
        assign w_words[k] = i_line[k*WORD_BITS +: WORD_BITS];
        assign o_line[k*WORD_BITS +: WORD_BITS] =
            (i_index == IDX_W'(k)) ? i_wdata : w_words[k];
    end

    assign o_word = w_words[i_index];

endmodule

`default_nettype wire

// File: rtl/line_buffer_dport.sv
// ============================================================================
// line_buffer_dport : single-line write-through buffer between a core data
//                     port and a line-granular memory arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module line_buffer_dport #(
    parameter int          LINE_BYTES = line_buffer_dport_pkg::LINE_BYTES,
    parameter logic [63:0] MMIO_LO    = line_buffer_dport_pkg::MMIO_LO,
    parameter logic [63:0] MMIO_HI    = line_buffer_dport_pkg::MMIO_HI
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    denable,
    input  logic                    dwenable,
    input  logic [63:0]             daddr,
    input  logic [63:0]             dwdata,
    output logic [63:0]             drdata,
    output logic                    ddone,
    output logic                    mrequest,
    output logic                    mwrenable,
    output logic [63:0]             maddr,
    input  logic [8*LINE_BYTES-1:0] mrdata,
    output logic [8*LINE_BYTES-1:0] mwdata,
    input  logic                    mdone
);

    import line_buffer_dport_pkg::*;

    localparam int c_LINE_BITS = 8 * LINE_BYTES;
    localparam int c_WORDS     = LINE_BYTES / 8;

    lb_state_e               r_state;
    lb_state_e               w_state_next;
    logic [c_LINE_BITS-1:0]  r_line;
    logic [57:0]             r_tag;
    logic                    r_valid;
    logic [63:3]             r_addr;
    logic                    r_we;
    logic [63:0]             r_wdata;
    logic                    r_cacheable;
    logic                    r_dropped;
    logic                    r_resp_d;

    logic                    w_cacheable;
    logic                    w_hit;
    logic                    w_accept;
    logic [c_LINE_BITS-1:0]  w_merged;
    logic [63:0]             w_rd_word;

    assign w_cacheable = is_cacheable(daddr, MMIO_LO, MMIO_HI);
    assign w_hit       = r_valid && (r_tag == daddr[63:6]) && w_cacheable;
    // The cycle right after RESP is a dead cycle so a held denable is not re-accepted.
    assign w_accept    = (r_state == ST_IDLE) && denable && !r_resp_d;

    line_word_mux #(
        .WORDS     (c_WORDS),
        .WORD_BITS (64)
    ) u_word_mux (
        .i_line  (r_line),
        .i_index (r_addr[5:3]),
        .i_wdata (r_wdata),
        .o_line  (w_merged),
        .o_word  (w_rd_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hit) w_state_next = dwenable ? ST_MERGE : ST_RESP;
                    else       w_state_next = ST_FILL;
                end
            end
            ST_FILL:  if (mdone) w_state_next = r_we ? ST_MERGE : ST_RESP;
            ST_MERGE: w_state_next = ST_WRITE;
            ST_WRITE: if (mdone) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so an async reset drops them at once.
    always_comb begin
        mrequest  = (r_state == ST_FILL) || (r_state == ST_WRITE);
        mwrenable = (r_state == ST_WRITE);
        maddr     = mrequest ? {r_addr[63:6], 6'b0} : 64'd0;
        mwdata    = (r_state == ST_WRITE) ? r_line : '0;
        ddone     = (r_state == ST_RESP) && denable && !r_dropped;
        drdata    = (r_state == ST_RESP) ? w_rd_word : 64'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_line      <= '0;
            r_tag       <= '0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cacheable <= 1'b0;
            r_dropped   <= 1'b0;
            r_resp_d    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_resp_d <= (r_state == ST_RESP);

            if (w_accept) begin
                r_addr      <= daddr[63:3];
                r_we        <= dwenable;
                r_wdata     <= dwdata;
                r_cacheable <= w_cacheable;
                r_dropped   <= 1'b0;
            end else if ((r_state != ST_IDLE) && !denable) begin
                r_dropped <= 1'b1;
            end

            if ((r_state == ST_FILL) && mdone) begin
                r_line  <= mrdata;
                r_tag   <= r_addr[63:6];
                r_valid <= r_cacheable;
            end

            if (r_state == ST_MERGE) r_line <= w_merged;

            if ((r_state == ST_WRITE) && mdone && !r_cacheable) r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_dport.sv
// ============================================================================
// tb_line_buffer_dport : directed + random checks against a memory-is-truth
//                        model with a single-line residency tracker
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_line_buffer_dport;

    logic         clk = 1'b0;
    logic         reset;
    logic         denable, dwenable, mdone;
    logic [63:0]  daddr, dwdata, drdata, maddr;
    logic         ddone, mrequest, mwrenable;
    logic [511:0] mrdata, mwdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_buffer_dport dut (
        .clk       (clk),
        .reset     (reset),
        .denable   (denable),
        .dwenable  (dwenable),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .drdata    (drdata),
        .ddone     (ddone),
        .mrequest  (mrequest),
        .mwrenable (mwrenable),
        .maddr     (maddr),
        .mrdata    (mrdata),
        .mwdata    (mwdata),
        .mdone     (mdone)
    );

    // Backing memory is the truth; the model only tracks which line is resident.
    logic [511:0] mem [logic [57:0]];
    bit           m_valid = 0;
    logic [57:0]  m_tag   = '0;
    logic [63:0]  last_rd;

    function automatic bit cacheable(input logic [63:0] a);
        return (a <= 64'd655360) || (a >= 64'd1048576);
    endfunction

    function automatic logic [511:0] mem_line(input logic [57:0] l);
        logic [511:0] v;
        if (!mem.exists(l)) begin
            for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
            mem[l] = v;
        end
        return mem[l];
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input bit we, input logic [63:0] addr, input logic [63:0] wd,
                          input int lat, input bit abandon);
        logic [57:0]  line;
        logic [511:0] l;
        bit           cach, hit, finished;
        int           exp_fills, exp_writes, fills, writes, wait_cnt, cyc, dones, quiet;
        line       = addr[63:6];
        cach       = cacheable(addr);
        hit        = m_valid && (m_tag == line) && cach;
        exp_fills  = hit ? 0 : 1;
        exp_writes = we ? 1 : 0;
        fills = 0; writes = 0; wait_cnt = 0; cyc = 0; dones = 0; quiet = 0;
        finished = 0;
        @(negedge clk);
        denable = 1'b1; dwenable = we; daddr = addr; dwdata = wd;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mdone = 1'b0;
            if (ddone) begin
                dones++;
                if (!we) begin
                    l = mem_line(line);
                    last_rd = drdata;
                    chk("drdata", drdata, l[int'(addr[5:3])*64 +: 64]);
                end
                if (hit && !we) chk("hit_latency", cyc, 1);
                denable = 1'b0;
                if (!abandon) finished = 1;
            end
            if (mrequest) begin
                chk("mwrenable", mwrenable, (fills < exp_fills) ? 1'b0 : 1'b1);
                if (wait_cnt >= lat) begin
                    chk("maddr", maddr, {line, 6'b0});
                    if (mwrenable) begin
                        writes++;
                        l = mem_line(line);
                        l[int'(addr[5:3])*64 +: 64] = wd;
                        chk("mwdata", mwdata, l);
                        mem[line] = l;
                    end else begin
                        fills++;
                        mrdata = mem_line(line);
                    end
                    mdone = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (abandon) begin
                if (cyc == 1) denable = 1'b0;
                if ((fills + writes) == (exp_fills + exp_writes) && !mrequest) quiet++;
                if (quiet >= 4) finished = 1;
            end
        end
        mdone = 1'b0;
        denable = 1'b0;
        chk("finished", finished, 1'b1);
        chk("fill_count", fills, exp_fills);
        chk("write_count", writes, exp_writes);
        chk("ddone_count", dones, abandon ? 0 : 1);
        if (!hit) begin
            m_valid = cach;
            m_tag   = line;
        end
        if (we && !cach) m_valid = 0;
        @(negedge clk);
    endtask

    function automatic logic [63:0] pick_base(input int i);
        case (i)
            0: return 64'h1000;
            1: return 64'h1040;
            2: return 64'h2000;
            3: return 64'hA0000;
            4: return 64'hB8000;
            5: return 64'hFFFC0;
            default: return 64'h100000;
        endcase
    endfunction

    initial begin
        logic [511:0] l;
        logic [63:0]  a;
        reset = 1'b0; denable = 1'b0; dwenable = 1'b0; daddr = '0; dwdata = '0;
        mdone = 1'b0; mrdata = '0; last_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_mrequest", mrequest, 1'b0);
        chk("rst_mwrenable", mwrenable, 1'b0);
        chk("rst_ddone", ddone, 1'b0);
        chk("rst_drdata", drdata, 64'd0);
        chk("rst_maddr", maddr, 64'd0);
        chk("rst_mwdata", mwdata, 512'd0);
        reset = 1'b1;
        @(negedge clk);

        l = mem_line(58'h40);
        l[64 +: 64] = 64'hAAAA;
        mem[58'h40] = l;
        access(0, 64'h1008, 64'd0, 3, 0);
        chk("read_miss_data", last_rd, 64'hAAAA);
        access(0, 64'h1008, 64'd0, 0, 0);
        chk("read_hit_data", last_rd, 64'hAAAA);
        access(1, 64'h1010, 64'h55, 1, 0);
        access(0, 64'h1010, 64'd0, 0, 0);
        chk("write_hit_readback", last_rd, 64'h55);
        access(0, 64'h1008, 64'd0, 0, 0);
        chk("write_hit_neighbour", last_rd, 64'hAAAA);

        access(0, 64'hB8000, 64'd0, 2, 0);
        access(0, 64'hB8000, 64'd0, 2, 0);

        access(0, 64'hA0000, 64'd0, 1, 0);
        access(0, 64'hA0000, 64'd0, 0, 0);
        access(0, 64'hA0008, 64'd0, 1, 0);
        access(0, 64'hFFFF8, 64'd0, 1, 0);
        access(0, 64'h100000, 64'd0, 1, 0);
        access(0, 64'h100000, 64'd0, 0, 0);
        access(1, 64'hB8010, 64'h1234_5678, 2, 0);

        // Reset two cycles into a fill
        @(negedge clk);
        denable = 1'b1; dwenable = 1'b0; daddr = 64'h3008;
        repeat (2) @(negedge clk);
        chk("fill_in_progress", mrequest, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_fill_mrequest", mrequest, 1'b0);
        chk("rst_mid_fill_maddr", maddr, 64'd0);
        denable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_valid = 0;
        @(negedge clk);
        access(0, 64'h3008, 64'd0, 1, 0);

        access(0, 64'h5000, 64'd0, 2, 1);
        access(0, 64'h5000, 64'd0, 0, 0);
        access(1, 64'h6018, 64'hDEAD_BEEF, 1, 1);
        access(0, 64'h6018, 64'd0, 0, 0);
        chk("abandoned_write_data", last_rd, 64'hDEAD_BEEF);

        // Stray arbiter completion while idle
        @(negedge clk);
        mdone = 1'b1;
        @(negedge clk);
        mdone = 1'b0;
        chk("stray_mdone_mrequest", mrequest, 1'b0);
        chk("stray_mdone_ddone", ddone, 1'b0);
        access(0, 64'h6018, 64'd0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            a = pick_base(int'($urandom_range(0, 6))) + 64'(8 * $urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   int'($urandom_range(0, 4)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_buffer_dport.md
LINE_BUFFER_DPORT -- requirements
Module: line_buffer_dport

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 64, bytes per line (fixed to 64 in this revision).
REQ-002 SHALL have parameter MMIO_LO, default 640*1024, exclusive lower bound of the uncached window.
REQ-003 SHALL have parameter MMIO_HI, default 1024*1024, exclusive upper bound of the uncached window.
REQ-004 Ports, in order:
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  denable  in  1  core data request, held high until done.
  dwenable  in  1  1 = write, 0 = read; stable while denable is high.
  daddr  in  64  byte address; bits [2:0] ignored.
  dwdata  in  64  write word.
  drdata  out  64  read word; valid in the done cycle.
  ddone  out  1  one-cycle completion pulse.
  mrequest  out  1  line request to arbiter, held high until mdone.
  mwrenable  out  1  1 = line write, 0 = line read.
  maddr  out  64  line address, bits [5:0] = 0.
  mrdata  in  512  fill line; valid in the mdone cycle.
  mwdata  out  512  line to write.
  mdone  in  1  one-cycle arbiter completion.

Function
REQ-005 SHALL hold one 512-bit line buffer with a 58-bit tag and a valid bit.
REQ-006 A cacheable address is one with daddr <= MMIO_LO or daddr >= MMIO_HI; hit = valid && tag == daddr[63:6] && cacheable.
REQ-007 Word select = daddr[5:3]; word k occupies line bits [64k+63:64k].
REQ-008 FSM states: IDLE, FILL, MERGE, WRITE, RESP.
REQ-009 IDLE, denable and read hit -> RESP. drdata = selected word; ddone asserts exactly 1 cycle after denable is sampled.
REQ-010 IDLE, denable and (miss or write) -> FILL.
  - Exception: a cacheable write hit skips FILL and goes to MERGE.
REQ-011 FILL behaviour:
  - mrequest=1, mwrenable=0, maddr={daddr[63:6],6'b0}.
  - On mdone: capture mrdata into the buffer and load the tag.
  - valid=1 only if cacheable.
  - Next state is MERGE for a write, RESP for a read.
REQ-012 MERGE: replace the selected word with dwdata (1 cycle), then go to WRITE.
REQ-013 WRITE behaviour:
  - mrequest=1, mwrenable=1, maddr = line address, mwdata = buffer.
  - On mdone -> RESP.
  - For an uncached address, valid clears on exit.
REQ-014 RESP: ddone=1 for exactly one cycle, then IDLE.
  - IDLE does not accept a new request in the cycle that follows RESP.
REQ-015 mrequest SHALL NOT deassert before mdone, and maddr/mwrenable/mwdata SHALL stay stable while it is high.
REQ-016 An mdone that arrives while mrequest is low SHALL be ignored.
REQ-017 If denable drops mid-transaction, the FSM SHALL still complete the transaction and return to IDLE without pulsing ddone.
REQ-018 Write policy is write-through: every write produces exactly one line write; no dirty state is kept.

Reset
REQ-019 While reset is low, all of the following hold: state=IDLE, valid=0, tag=0, buffer=0, ddone=0, drdata=0, mrequest=0, mwrenable=0, maddr=0, mwdata=0.
REQ-020 Reset asserted mid-FILL/WRITE SHALL abandon the transaction immediately, with mrequest low in that same cycle.

Structure
REQ-021 The FSM state enum, LINE_BYTES, MMIO_LO and MMIO_HI SHALL live in the shared global package.
  - The core's MMIO predicate SHALL use the same constants.
REQ-022 The word-merge and word-select logic SHALL be one sub-module, line_word_mux (line, index, wdata -> merged line, read word).

Verification
REQ-023 Read miss:
  - Stimulus: read 0x1008 with mrdata word1=0xAAAA, then mdone after 3 cycles.
  - Response: maddr=0x1000, drdata=0xAAAA, a single ddone.
REQ-024 Read hit:
  - Stimulus: repeat the read of 0x1008.
  - Response: no mrequest; ddone 1 cycle later; drdata=0xAAAA.
REQ-025 Write hit:
  - Stimulus: write 0x1010 = 0x55.
  - Response: one line write to 0x1000 with mwdata word2=0x55 and the other words unchanged; a following read of 0x1010 hits and returns 0x55.
REQ-026 MMIO read:
  - Stimulus: read 0xB8000 twice.
  - Response: two separate fills; valid stays 0.
REQ-027 Reset mid-FILL:
  - Stimulus: drive reset low 2 cycles into FILL.
  - Response: mrequest=0 immediately; after release, a read of the same address misses again.
REQ-028 Abandoned request:
  - Stimulus: drop denable during FILL.
  - Response: the fill completes, no ddone is produced, and the next request is accepted from IDLE.
